ldtu_ofifo_nlane: RTL
=====================

Name: ldtu_ofifo_nlane

Overview:
Parametrised output storage FIFO that buffers 32-bit encoded words from the control unit. It drains up to NLanes words per read request onto NLanes parallel serializer lanes. It generalises the fixed four-lane output path with a configurable lane count and depth, partial-frame idle fill, an almost-full flag and a saturating overflow counter. It sits between the control unit and the serializer/ATU output mux.

Parameters:
Nbits_32, 32, data word width
FifoDepth_buff, 16, storage depth in words; power of 2
bits_ptr, 4, log2(FifoDepth_buff)
NLanes, 4, number of output lanes; 1..FifoDepth_buff
AFullThr, 12, occupancy at or above which almost_full asserts
IdleWord, 32'hEAAAAAAA, filler word for lanes with no data

Ports:
CLK  in  1  single system clock; all logic on rising edge
rst_b  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents, sampled each cycle
synch  in  1  synch mode: all lanes drive synch_pattern; no pops
synch_pattern  in  Nbits_32  pattern driven during synch mode
write_signal  in  1  push data_in_32 this cycle
data_in_32  in  Nbits_32  word to store
read_signal  in  1  serializer frame request; pops up to NLanes words
DATA32_out  out  NLanes*Nbits_32  lane k on bits [k*Nbits_32 +: Nbits_32]
lane_valid  out  NLanes  per-lane flag: lane carries FIFO data (not filler)
full_signal  out  1  count == FifoDepth_buff
almost_full  out  1  count >= AFullThr
losing_data  out  1  one-cycle pulse when a write is dropped
overflow_cnt  out  8  saturating count of dropped writes
count  out  bits_ptr+1  current occupancy

Behaviour:
- Clock CLK; reset rst_b is asynchronous, active-low. Reset values: pointers 0, count 0, DATA32_out all lanes = IdleWord, lane_valid 0, full_signal 0, almost_full 0, losing_data 0, overflow_cnt 0.
- Pointers are bits_ptr wide and wrap modulo FifoDepth_buff. count is tracked explicitly, bits_ptr+1 wide.
- Pop: npop = min(count, NLanes), evaluated when read_signal=1 and synch=0 and flush=0.
  - Lane k (k<npop) gets mem[rd_ptr+k] with lane_valid[k]=1.
  - Lanes k>=npop get IdleWord with lane_valid[k]=0.
  - rd_ptr advances by npop.
  - Outputs are registered: 1-cycle latency from read_signal. Outputs hold between reads.
- Push: accepted iff (count - npop) < FifoDepth_buff. A simultaneous pop frees space for the push in the same cycle.
  - Write into mem[wr_ptr], then wr_ptr+1.
  - count_next = count - npop + push.
- Drop: write_signal=1 and not accepted -> data discarded, losing_data=1 next cycle, overflow_cnt+1 (saturates at 255, never wraps).
- Synch mode (synch=1): DATA32_out all lanes = synch_pattern, lane_valid=0, registered with 1-cycle latency. No pops occur. Writes are still accepted. On exit, lanes keep synch_pattern until the next read.
- Flush (flush=1): next cycle rd_ptr=wr_ptr=0, count=0, lanes=IdleWord, lane_valid=0.
  - A write in the flush cycle is discarded and is not counted as overflow.
  - overflow_cnt is preserved across flush; only rst_b clears it.
- Priority: rst_b > flush > synch > normal read.
- Flags: full_signal and almost_full are registered from count_next and are valid in the same cycle as count.
- Empty read (count=0, read_signal=1): all lanes IdleWord, lane_valid=0, no pointer change.
- Reset asserted mid-frame: all state clears immediately; no partial outputs survive.

Decomposition:
- Shared package ldtu_pkg: IdleWord constant, default Nbits_32, NLanes, FifoDepth_buff, and a function computing min(count, NLanes).
- Sub-module ldtu_ofifo_mem: register-file storage with 1 write port and NLanes combinational read ports indexed rd_ptr+k (mod depth), no reset on the array.
- Top: pointers, count, flags, lane assembly, overflow logic.

Test Plan:
- Write 0x1..0x6, then read_signal once -> next cycle lanes = 1,2,3,4, lane_valid=4'b1111, count=2. Read again -> lanes = 5,6,Idle,Idle, lane_valid=4'b0011, count=0.
- Write 16 words with no reads -> full_signal=1, almost_full asserted at count 12. 17th write -> losing_data pulse, overflow_cnt=1. Then write+read in the same cycle while full -> write accepted, count=13.
- Write 20 words into a 4-deep prefill so rd/wr pointers wrap past 15 -> popped data order preserved, count correct at each step.
- synch=1, synch_pattern=0x5A5A5A5A with read_signal=1 and 8 words stored -> all lanes 0x5A5A5A5A, count stays 8. Write during synch -> count=9.
- flush=1 with 10 words stored and a concurrent write -> count=0, lanes Idle, overflow_cnt unchanged.
- Drive rst_b low mid-read (no clock edge) -> outputs go to reset values immediately; 300 dropped writes -> overflow_cnt=255.

Source files
------------

// File: rtl/ldtu_pkg.sv
// Shared constants and helpers for the LDTU output FIFO.
// Defaults mirror the fixed four-lane, sixteen-deep output path.
package ldtu_pkg;

    localparam int          DefNbits   = 32;
    localparam int          DefDepth   = 16;
    localparam int          DefNLanes  = 4;
    localparam logic [31:0] IDLE_WORD  = 32'hEAAAAAAA;

    // Number of words a frame request can actually take.
    function automatic int min_pop(input int cnt, input int lanes);
        return (cnt < lanes) ? cnt : lanes;
    endfunction

endpackage

// File: rtl/ldtu_ofifo_mem.sv
// Register-file storage: one write port, NLanes combinational read ports
// at consecutive addresses starting from rd_ptr (wrapping modulo depth).
module ldtu_ofifo_mem
    import ldtu_pkg::*;
#(
    parameter int Nbits_32       = DefNbits,
    parameter int FifoDepth_buff = DefDepth,
    parameter int bits_ptr       = 4,
    parameter int NLanes         = DefNLanes
) (
    input  logic                       CLK,
    input  logic                       we,
    input  logic [bits_ptr-1:0]        wr_ptr,
    input  logic [Nbits_32-1:0]        wdata,
    input  logic [bits_ptr-1:0]        rd_ptr,
    output logic [NLanes*Nbits_32-1:0] rdata
);

    logic [Nbits_32-1:0] mem [FifoDepth_buff];

    // NOTE: the array is deliberately not reset; count and valid flags
    // guarantee stale entries are never presented as data.
    always_ff @(posedge CLK) begin
        if (we) mem[wr_ptr] <= wdata;
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NLanes; k++)
            rdata[k*Nbits_32 +: Nbits_32] = mem[rd_ptr + bits_ptr'(k)];
    end

endmodule

// File: rtl/ldtu_ofifo_nlane.sv
// Output FIFO draining up to NLanes words per frame request onto parallel
// serializer lanes, with idle fill, synch pattern, flush and overflow count.
module ldtu_ofifo_nlane
    import ldtu_pkg::*;
#(
    parameter int          Nbits_32       = DefNbits,
    parameter int          FifoDepth_buff = DefDepth,
    parameter int          bits_ptr       = 4,
    parameter int          NLanes         = DefNLanes,
    parameter int          AFullThr       = 12,
    parameter logic [31:0] IdleWord       = IDLE_WORD
) (
    input  logic                       CLK,
    input  logic                       rst_b,
    input  logic                       flush,
    input  logic                       synch,
    input  logic [Nbits_32-1:0]        synch_pattern,
    input  logic                       write_signal,
    input  logic [Nbits_32-1:0]        data_in_32,
    input  logic                       read_signal,
    output logic [NLanes*Nbits_32-1:0] DATA32_out,
    output logic [NLanes-1:0]          lane_valid,
    output logic                       full_signal,
    output logic                       almost_full,
    output logic                       losing_data,
    output logic [7:0]                 overflow_cnt,
    output logic [bits_ptr:0]          count
);

    localparam logic [bits_ptr:0] DEPTH = (bits_ptr+1)'(FifoDepth_buff);
    localparam logic [bits_ptr:0] AFULL = (bits_ptr+1)'(AFullThr);

    logic [bits_ptr-1:0]        rd_ptr, wr_ptr;
    logic [bits_ptr:0]          npop, count_next;
    logic                       read_en, push, drop;
    logic [NLanes*Nbits_32-1:0] rdata, lanes_next;
    logic [NLanes-1:0]          valid_next;

    ldtu_ofifo_mem #(
        .Nbits_32      (Nbits_32),
        .FifoDepth_buff(FifoDepth_buff),
        .bits_ptr      (bits_ptr),
        .NLanes        (NLanes)
    ) u_mem (
        .CLK   (CLK),
        .we    (push),
        .wr_ptr(wr_ptr),
        .wdata (data_in_32),
        .rd_ptr(rd_ptr),
        .rdata (rdata)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        read_en    = read_signal && !synch && !flush;
        npop       = read_en ? (bits_ptr+1)'(min_pop(int'(count), NLanes)) : '0;
        push       = write_signal && !flush && ((count - npop) < DEPTH);
        drop       = write_signal && !flush && !push;
        count_next = flush ? '0 : count - npop + {{bits_ptr{1'b0}}, push};

        lanes_next = DATA32_out;
        valid_next = lane_valid;
        if (flush || synch || read_en) begin
            for (int k = 0; k < NLanes; k++) begin
                if (flush) begin
                    lanes_next[k*Nbits_32 +: Nbits_32] = IdleWord[Nbits_32-1:0];
                    valid_next[k] = 1'b0;
                end else if (synch) begin
                    lanes_next[k*Nbits_32 +: Nbits_32] = synch_pattern;
                    valid_next[k] = 1'b0;
                end else if (k < int'(npop)) begin
                    lanes_next[k*Nbits_32 +: Nbits_32] = rdata[k*Nbits_32 +: Nbits_32];
                    valid_next[k] = 1'b1;
                end else begin
                    lanes_next[k*Nbits_32 +: Nbits_32] = IdleWord[Nbits_32-1:0];
                    valid_next[k] = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            DATA32_out   <= {NLanes{IdleWord[Nbits_32-1:0]}};
            lane_valid   <= '0;
            full_signal  <= 1'b0;
            almost_full  <= 1'b0;
            losing_data  <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + npop[bits_ptr-1:0];
                if (push) wr_ptr <= wr_ptr + 1'b1;
            end
            count       <= count_next;
            DATA32_out  <= lanes_next;
            lane_valid  <= valid_next;
            full_signal <= (count_next == DEPTH);
            almost_full <= (count_next >= AFULL);
            losing_data <= drop;
            // Saturate rather than wrap so a long overflow stays visible.
            if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

endmodule
